// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state type and default datapath widths.
package cpu_pkg;

    localparam int PCW        = 10;
    localparam int IW         = 8;
    localparam int START_ADDR = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next fetch address: sequential increment or branch target relative to inst_pc.
module pc_next #(
    parameter int PCW = cpu_pkg::PCW
) (
    input  logic [PCW-1:0] i_fetch_pc,
    input  logic [PCW-1:0] i_inst_pc,
    input  logic [7:0]     i_branch_offset,
    input  logic           i_take_branch,
    output logic [PCW-1:0] o_next_pc
);

    logic [PCW-1:0] w_inc_pc;
    logic [PCW-1:0] w_target_pc;

    // Both paths wrap modulo 2^PCW; the offset is sign-extended to PCW bits.
    assign w_inc_pc    = i_fetch_pc + PCW'(1);
    assign w_target_pc = i_inst_pc + PCW'($signed(i_branch_offset));
    assign o_next_pc   = i_take_branch ? w_target_pc : w_inc_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a synchronous ROM, tracks inst_pc, handles stall/branch/halt.
module fetch_unit #(
    parameter int             PCW        = cpu_pkg::PCW,
    parameter int             IW         = cpu_pkg::IW,
    parameter logic [PCW-1:0] START_ADDR = PCW'(cpu_pkg::START_ADDR)
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           start,
    input  logic           stall,
    input  logic           halt,
    input  logic           branch_taken,
    input  logic [7:0]     branch_offset,
    output logic [PCW-1:0] imem_addr,
    input  logic [IW-1:0]  imem_data,
    output logic [IW-1:0]  instruction,
    output logic           inst_valid,
    output logic [PCW-1:0] inst_pc,
    output logic           done,
    output logic [15:0]    inst_count
);

    import cpu_pkg::*;

    fetch_state_t   r_state;
    logic [PCW-1:0] r_fetch_pc;
    logic [PCW-1:0] r_inst_pc;
    logic           r_valid;
    logic           r_done;
    logic [15:0]    r_count;

    logic           w_advance;
    logic           w_branch;
    logic [PCW-1:0] w_next_pc;

    // halt has priority over a branch on the same instruction.
    assign w_advance = (r_state == RUN) && !stall && r_valid;
    assign w_branch  = w_advance && !halt && branch_taken;

    pc_next #(.PCW(PCW)) u_pc_next (
        .i_fetch_pc      (r_fetch_pc),
        .i_inst_pc       (r_inst_pc),
        .i_branch_offset (branch_offset),
        .i_take_branch   (w_branch),
        .o_next_pc       (w_next_pc)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_fetch_pc <= START_ADDR;
            r_inst_pc  <= START_ADDR;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE, HALTED: begin
                    if (start) begin
                        r_fetch_pc <= START_ADDR;
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_state    <= PRIME;
                    end
                end
                PRIME: begin
                    r_inst_pc  <= r_fetch_pc;
                    r_fetch_pc <= w_next_pc;
                    r_valid    <= 1'b1;
                    r_state    <= RUN;
                end
                RUN: begin
                    if (!stall) begin
                        if (r_valid && (r_count != '1))
                            r_count <= r_count + 16'd1;
                        if (r_valid && halt) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= HALTED;
                        end else if (w_branch) begin
                            r_fetch_pc <= w_next_pc;
                            r_valid    <= 1'b0;
                        end else begin
                            r_inst_pc  <= r_fetch_pc;
                            r_fetch_pc <= w_next_pc;
                            r_valid    <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_addr   = r_fetch_pc;
    assign instruction = imem_data;
    assign inst_valid  = r_valid;
    assign inst_pc     = r_inst_pc;
    assign done        = r_done;
    assign inst_count  = r_count;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PCW, default 10, program-counter and instruction-memory address width.
REQ-002 Parameter IW, default 8, instruction width; SHALL equal the decoder's instruction width.
REQ-003 Parameter START_ADDR, default 0, PC loaded on each start.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins execution from START_ADDR.
REQ-007 stall  input  1  downstream not ready; freeze fetch state.
REQ-008 halt  input  1  decoder flags the current valid instruction as HALT.
REQ-009 branch_taken  input  1  execute resolves the current valid instruction as a taken BLT/BNE.
REQ-010 branch_offset  input  8  signed two's-complement offset, relative to inst_pc.
REQ-011 imem_addr  output  PCW  synchronous instruction-ROM read address; data arrives next cycle.
REQ-012 imem_data  input  IW  ROM read data.
REQ-013 instruction  output  IW  instruction to decoder; equals imem_data.
REQ-014 inst_valid  output  1  instruction is the real instruction at inst_pc.
REQ-015 inst_pc  output  PCW  address of the current instruction.
REQ-016 done  output  1  program halted.
REQ-017 inst_count  output  16  retired-instruction counter.

Function
REQ-018 FSM states: IDLE, PRIME, RUN, HALTED.
REQ-019 IDLE: start=1 -> fetch_pc<=START_ADDR, inst_count<=0, done<=0, go PRIME; otherwise hold.
REQ-020 imem_addr SHALL equal fetch_pc in every state.
REQ-021 PRIME, one cycle: inst_pc<=fetch_pc, fetch_pc<=fetch_pc+1, inst_valid<=1, go RUN; first instruction is valid 2 cycles after the start pulse.
REQ-022 RUN with stall=1: fetch_pc, inst_pc, inst_valid and inst_count hold; branch_taken and halt are ignored.
REQ-023 RUN with stall=0 and inst_valid=1: inst_count increments, saturating at 16'hFFFF.
REQ-024 RUN, stall=0, inst_valid=1, halt=1: go HALTED, inst_valid<=0, done<=1; PC registers freeze. halt wins over branch_taken.
REQ-025 RUN, stall=0, inst_valid=1, branch_taken=1: fetch_pc<=inst_pc+sext(branch_offset), inst_valid<=0. This squashes the one in-flight instruction (1-cycle bubble).
REQ-026 RUN with stall=0 otherwise: inst_pc<=fetch_pc, fetch_pc<=fetch_pc+1, inst_valid<=1.
REQ-027 PC arithmetic is modulo 2^PCW; increment and branch target wrap silently.
REQ-028 halt and branch_taken are ignored while inst_valid=0.
REQ-029 HALTED: done stays 1; start=1 behaves exactly as in IDLE, clears done and restarts.
REQ-030 start is ignored in PRIME and RUN.

Reset
REQ-031 RESET_N low SHALL immediately set state=IDLE, fetch_pc=START_ADDR, inst_pc=START_ADDR, inst_valid=0, done=0, inst_count=0.
REQ-032 Reset asserted mid-RUN aborts the program; no further inst_valid until a new start.
REQ-033 Deassertion needs no start; the block waits in IDLE.

Structure
REQ-034 Shared package cpu_pkg SHALL hold the state enum fetch_state_t, the widths PCW and IW, and START_ADDR.
REQ-035 A single sub-module pc_next SHALL compute the next fetch_pc combinationally from the increment and branch-target paths.
REQ-036 All remaining logic lives in fetch_unit; no additional memories.

Verification
REQ-037 Reset, then start pulse at cycle 0 with ROM[0..2]=A,B,C -> inst_valid=1 at cycle 2 with inst_pc=0, instruction=A; then pc 1, 2 on consecutive cycles.
REQ-038 stall=1 for 3 cycles while inst_pc=5 -> inst_pc stays 5, imem_addr stays 6, inst_count unchanged; resumes with pc 6.
REQ-039 branch_taken=1 with offset=8'hFC at inst_pc=10 -> next cycle inst_valid=0; following cycle inst_valid=1 with inst_pc=6. Repeat with offset 8'h05 at pc=1021 (PCW=10) -> target 2.
REQ-040 halt=1 together with branch_taken=1 at pc=7 -> done=1 next cycle, inst_valid=0, inst_count=8; a later start -> pc 0 valid 2 cycles later, done=0.
REQ-041 RESET_N pulled low asynchronously mid-cycle during RUN -> outputs reach reset values before the next edge; start after release runs normally.
